// File: rtl/vga_mem_arbiter.sv
// Arbitrates a single-port glyph/tile RAM between pixel-fetch reads (absolute priority)
// and buffered stopwatch digit writes, which drain on cycles without a read request.
module vga_mem_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 8,
    parameter int WQ_DEPTH   = 4,
    parameter int STARVE_MAX = 800
) (
    input  logic              board_clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              wr_starved,
    output logic              wq_empty,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int PTR_W = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] FULL_OCC   = CNT_W'(WQ_DEPTH);
    localparam logic [SC_W-1:0]  STARVE_TOP = SC_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;
    state_t state_reg, state_next;

    logic [ADDR_W-1:0] wq_addr_mem [WQ_DEPTH];
    logic [DATA_W-1:0] wq_data_mem [WQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg, head_ptr;
    logic [CNT_W-1:0]  occ_reg, occ_next, pend_occ;
    logic [SC_W-1:0]   starve_reg, starve_next;
    logic              wr_ready_reg, rd_valid_reg;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next, rd_hold_reg;
    logic              push, pop;

    // The WR-state entry retires at the end of this cycle, so the next grant
    // decision looks past it to the following entry.
    always_comb begin
        pop            = (state_reg == WR);
        push           = wr_req && wr_ready_reg;
        pend_occ       = occ_reg - CNT_W'(pop);
        head_ptr       = rd_ptr_reg + PTR_W'(pop);
        occ_next       = occ_reg + CNT_W'(push) - CNT_W'(pop);
        state_next     = IDLE;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        if (rd_req) begin
            state_next    = RD;
            mem_addr_next = rd_addr;
        end else if (pend_occ != '0) begin
            state_next     = WR;
            mem_addr_next  = wq_addr_mem[head_ptr];
            mem_wdata_next = wq_data_mem[head_ptr];
        end
        starve_next = starve_reg;
        if (state_next == WR || occ_reg == '0)
            starve_next = '0;
        else if (!pop && starve_reg != STARVE_TOP)
            starve_next = starve_reg + 1'b1;
    end

    always_ff @(posedge board_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            occ_reg       <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            wr_ready_reg  <= 1'b1;
            starve_reg    <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            rd_valid_reg  <= 1'b0;
            rd_hold_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            occ_reg       <= occ_next;
            wr_ptr_reg    <= wr_ptr_reg + PTR_W'(push);
            rd_ptr_reg    <= rd_ptr_reg + PTR_W'(pop);
            wr_ready_reg  <= (occ_next != FULL_OCC);
            starve_reg    <= starve_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            rd_valid_reg  <= (state_reg == RD);
            if (rd_valid_reg)
                rd_hold_reg <= mem_rdata;
        end
    end

    // Queue payload storage needs no reset; occupancy and pointers guard it.
    always_ff @(posedge board_clk) begin
        if (push) begin
            wq_addr_mem[wr_ptr_reg] <= wr_addr;
            wq_data_mem[wr_ptr_reg] <= wr_data;
        end
    end

    assign mem_en     = (state_reg != IDLE);
    assign mem_we     = (state_reg == WR);
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign rd_valid   = rd_valid_reg;
    assign rd_data    = rd_valid_reg ? mem_rdata : rd_hold_reg;
    assign wr_ready   = wr_ready_reg;
    assign wr_starved = (starve_reg == STARVE_TOP);
    assign wq_empty   = (occ_reg == '0) && (state_reg != WR);
endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Randomized scoreboard bench for vga_mem_arbiter: a queue-based reference model predicts
// every cycle's outputs and read data; a separate monitor compares them against the DUT.
module tb_vga_mem_arbiter;
    localparam int AW     = 11;
    localparam int DW     = 8;
    localparam int DEPTH  = 4;
    localparam int STARVE = 8;

    logic          board_clk, rst_n;
    logic          rd_req, rd_valid, wr_req, wr_ready, wr_starved, wq_empty;
    logic          mem_en, mem_we;
    logic [AW-1:0] rd_addr, wr_addr, mem_addr;
    logic [DW-1:0] rd_data, wr_data, mem_wdata, mem_rdata;

    vga_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WQ_DEPTH(DEPTH), .STARVE_MAX(STARVE)) dut (
        .board_clk(board_clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .wr_starved(wr_starved), .wq_empty(wq_empty),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial board_clk = 1'b0;
    always #5 board_clk = ~board_clk;

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        if (a == 11'h123) return 8'hA5;
        return a[7:0] ^ {5'b0, a[10:8]} ^ 8'h5A;
    endfunction

    // Behavioural single-port RAM with one-cycle registered read.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    bit            ram_wr [0:(1<<AW)-1];
    always @(posedge board_clk) begin
        if (mem_en && mem_we) begin
            ram[mem_addr]    <= mem_wdata;
            ram_wr[mem_addr] <= 1'b1;
        end
        if (mem_en && !mem_we)
            mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : pattern(mem_addr);
    end

    typedef struct {
        bit            in_rst;
        bit            en;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            rdv;
        bit            rdy;
        bit            starved;
        bit            empty;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] exp_rd[$];
    bit            done = 1'b0;
    int            checks = 0;
    int            errors = 0;

    // Reference model: what occupies the RAM port this cycle, pending writes in order,
    // read-valid pipeline, head wait counter and the RAM contents writes should produce.
    int            m_grant = 0;  // 0 none, 1 read, 2 write
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [AW-1:0] m_wq_addr[$];
    logic [DW-1:0] m_wq_data[$];
    bit            m_rdv = 1'b0;
    int            m_starve = 0;
    logic [DW-1:0] ref_mem [int];

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return pattern(a);
    endfunction

    task automatic do_cycle(input bit rst, input bit rq, input logic [AW-1:0] ra,
                            input bit wq, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        exp_t          e;
        int            old_size, pend, idx, n_grant, n_starve;
        logic [AW-1:0] n_addr;
        logic [DW-1:0] n_wdata;
        @(posedge board_clk);
        #1;
        rst_n = !rst; rd_req = rq; rd_addr = ra; wr_req = wq; wr_addr = wa; wr_data = wd;
        if (rst) begin
            e = '{1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1};
            exp_q.push_back(e);
            m_grant = 0; m_addr = '0; m_wdata = '0; m_rdv = 1'b0; m_starve = 0;
            m_wq_addr.delete(); m_wq_data.delete(); exp_rd.delete();
            return;
        end
        old_size  = m_wq_addr.size();
        e.in_rst  = 1'b0;
        e.en      = (m_grant != 0);
        e.we      = (m_grant == 2);
        e.addr    = m_addr;
        e.wdata   = m_wdata;
        e.rdv     = m_rdv;
        e.rdy     = (old_size < DEPTH);
        e.starved = (m_starve == STARVE);
        e.empty   = (old_size == 0) && (m_grant != 2);
        exp_q.push_back(e);

        if (m_grant == 2) ref_mem[int'(m_addr)] = m_wdata;
        if (rq) exp_rd.push_back(ref_rd(ra));
        pend = old_size - ((m_grant == 2) ? 1 : 0);
        n_addr = m_addr; n_wdata = m_wdata;
        if (rq) begin
            n_grant = 1; n_addr = ra;
        end else if (pend > 0) begin
            idx = (m_grant == 2) ? 1 : 0;
            n_grant = 2; n_addr = m_wq_addr[idx]; n_wdata = m_wq_data[idx];
        end else begin
            n_grant = 0;
        end
        n_starve = m_starve;
        if (n_grant == 2 || old_size == 0) n_starve = 0;
        else if (m_grant != 2 && m_starve < STARVE) n_starve = m_starve + 1;
        if (m_grant == 2) begin
            void'(m_wq_addr.pop_front());
            void'(m_wq_data.pop_front());
        end
        if (wq && old_size < DEPTH) begin
            m_wq_addr.push_back(wa);
            m_wq_data.push_back(wd);
        end
        m_rdv = (m_grant == 1);
        m_grant = n_grant; m_addr = n_addr; m_wdata = n_wdata; m_starve = n_starve;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) do_cycle(1'b0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    // Stimulus
    initial begin
        rst_n = 1'b0; rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        for (int k = 0; k < 3; k++) do_cycle(1'b1, 1'b0, '0, 1'b0, '0, '0);
        idle(6);
        do_cycle(1'b0, 1'b1, 11'h123, 1'b0, '0, '0);
        idle(4);
        do_cycle(1'b0, 1'b0, '0, 1'b1, 11'h010, 8'h3C);
        idle(5);
        do_cycle(1'b0, 1'b1, 11'h010, 1'b0, '0, '0);
        idle(3);
        for (int k = 0; k < 20; k++)
            do_cycle(1'b0, 1'b1, AW'($urandom_range(0, 2047)), k < 5,
                     AW'(11'h200 + k), DW'($urandom));
        idle(10);
        for (int k = 0; k < 14; k++)
            do_cycle(1'b0, 1'b1, AW'($urandom_range(0, 63)), k == 0, 11'h300, 8'h77);
        idle(6);
        for (int k = 0; k < 100; k++)
            do_cycle(1'b0, k[0], AW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                     AW'($urandom_range(0, 31)), DW'($urandom));
        for (int k = 0; k < 150; k++)
            do_cycle(1'b0, $urandom_range(0, 99) < 55, AW'($urandom_range(0, 31)),
                     $urandom_range(0, 99) < 45, AW'($urandom_range(0, 31)), DW'($urandom));
        idle(8);
        do_cycle(1'b0, 1'b1, 11'h123, 1'b1, 11'h040, 8'hE1);
        do_cycle(1'b1, 1'b0, '0, 1'b0, '0, '0);
        do_cycle(1'b1, 1'b0, '0, 1'b0, '0, '0);
        idle(6);
        do_cycle(1'b0, 1'b0, '0, 1'b1, 11'h041, 8'hD2);
        idle(1);
        do_cycle(1'b1, 1'b0, '0, 1'b0, '0, '0);
        do_cycle(1'b1, 1'b0, '0, 1'b0, '0, '0);
        idle(6);
        do_cycle(1'b0, 1'b1, 11'h041, 1'b0, '0, '0);
        do_cycle(1'b0, 1'b1, 11'h010, 1'b0, '0, '0);
        idle(6);
        @(negedge board_clk);
        #1;
        done = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge board_clk);
            if (done) begin
                chk("rd_drain", exp_rd.size(), 0);
                chk("wr_drain", {31'b0, wq_empty}, 1);
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (e.in_rst) begin
                    chk("rst_mem_en", mem_en, 0);
                    chk("rst_mem_we", mem_we, 0);
                    chk("rst_mem_addr", mem_addr, 0);
                    chk("rst_mem_wdata", mem_wdata, 0);
                    chk("rst_rd_valid", rd_valid, 0);
                    chk("rst_rd_data", rd_data, 0);
                    chk("rst_wr_ready", wr_ready, 1);
                    chk("rst_wr_starved", wr_starved, 0);
                    chk("rst_wq_empty", wq_empty, 1);
                end else begin
                    chk("mem_en", mem_en, e.en);
                    chk("mem_we", mem_we, e.we);
                    chk("we_without_en", mem_we & ~mem_en, 0);
                    if (e.en) chk("mem_addr", mem_addr, e.addr);
                    if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                    chk("rd_valid", rd_valid, e.rdv);
                    chk("wr_ready", wr_ready, e.rdy);
                    chk("wr_starved", wr_starved, e.starved);
                    chk("wq_empty", wq_empty, e.empty);
                    if (mem_en && mem_we)
                        $display("%0t write addr=%h data=%h", $time, mem_addr, mem_wdata);
                    if (rd_valid === 1'b1) begin
                        if (exp_rd.size() == 0) begin
                            chk("rd_unexpected", 1, 0);
                        end else begin
                            $display("%0t read  data=%h", $time, rd_data);
                            chk("rd_data", rd_data, exp_rd.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule
